// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button debouncer.
//   CLK_FREQ_HZ / SAMPLE_HZ  : system clock and filter sample rate
//   TICK_DIV_DEFAULT         : clk cycles per sample tick
//   DEBOUNCE_MS / LONG_MS    : default debounce and long-press times
//   cnt_width()              : bits needed to hold 0..max_val
package btn_pkg;

   localparam int CLK_FREQ_HZ      = 50_000_000;
   localparam int SAMPLE_HZ        = 1000;
   localparam int TICK_DIV_DEFAULT = CLK_FREQ_HZ / SAMPLE_HZ;
   localparam int DEBOUNCE_MS      = 20;
   localparam int LONG_MS          = 1000;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between board pins and the debouncer.
//   btn_in      : raw asynchronous pins (driven by the pin side / master)
//   btn_level   : debounced level, 1 = pressed
//   btn_press   : 1-cycle pulse on accepted press
//   btn_release : 1-cycle pulse on accepted release
//   btn_long    : 1-cycle pulse when the hold reaches the long threshold
//   btn_held    : high while pressed beyond the long threshold
interface btn_debounce_multi_if #(
   parameter int NUM_BTN = 4
);
   logic [NUM_BTN-1:0] btn_in;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_long;
   logic [NUM_BTN-1:0] btn_held;

   modport master (
      output btn_in,
      input  btn_level, btn_press, btn_release, btn_long, btn_held
   );

   modport slave (
      input  btn_in,
      output btn_level, btn_press, btn_release, btn_long, btn_held
   );
endinterface

// File: rtl/btn_debounce_chan.sv
// One debouncer channel: 2-FF synchroniser, consecutive-sample filter and
// long-press timer, all advancing on the shared sample_tick.
//   clk, rst     : system clock, synchronous active-high reset
//   sample_tick  : one-cycle strobe from the shared prescaler
//   pin          : raw asynchronous pin
//   level_o      : debounced level, 1 = pressed
//   press_o      : 1-cycle pulse on accepted press
//   release_o    : 1-cycle pulse on accepted release
//   long_o       : 1-cycle pulse when the hold reaches LONG_SAMPLES ticks
//   held_o       : high while pressed and the long threshold is reached
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int STABLE_SAMPLES = 20,
   parameter int LONG_SAMPLES   = 1000,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic pin,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic held_o
);

   localparam int DW = cnt_width(STABLE_SAMPLES);
   localparam int HW = cnt_width(LONG_SAMPLES);

   localparam logic          INACTIVE  = (ACTIVE_LOW != 0);
   localparam logic [DW-1:0] DIFF_LAST = DW'(STABLE_SAMPLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_SAMPLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_SAMPLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [DW-1:0] diff_cnt_q, diff_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          raw;

   // Normalise polarity so raw = 1 means pressed.
   assign raw = sync2_q ^ INACTIVE;

   always_comb begin
      sync1_d    = pin;
      sync2_d    = sync1_q;
      level_d    = level_q;
      diff_cnt_d = diff_cnt_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      if (sample_tick) begin
         if (raw == level_q) begin
            diff_cnt_d = '0;
         end else if (diff_cnt_q == DIFF_LAST) begin
            level_d    = raw;
            diff_cnt_d = '0;
            press_d    = raw;
            release_d  = ~raw;
         end else begin
            diff_cnt_d = diff_cnt_q + DW'(1);
         end

         // The press acceptance tick sees level_q=0 and so does not count;
         // the release acceptance tick clears the hold instead of counting.
         if (release_d) begin
            hold_cnt_d = '0;
         end else if (level_q && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            long_d     = (hold_cnt_q == HOLD_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= INACTIVE;
         sync2_q    <= INACTIVE;
         level_q    <= 1'b0;
         diff_cnt_q <= '0;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         level_q    <= level_d;
         diff_cnt_q <= diff_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign held_o    = level_q && (hold_cnt_q == HOLD_MAX);

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel key debouncer: one shared sample-tick prescaler feeding
// NUM_BTN independent debouncer channels.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : button bundle (raw pins in; level/press/release/long/held out)
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int NUM_BTN        = 4,
   parameter int TICK_DIV       = TICK_DIV_DEFAULT,
   parameter int STABLE_SAMPLES = DEBOUNCE_MS * SAMPLE_HZ / 1000,
   parameter int LONG_SAMPLES   = LONG_MS * SAMPLE_HZ / 1000,
   parameter int ACTIVE_LOW     = 1
) (
   input logic                 clk,
   input logic                 rst,
   btn_debounce_multi_if.slave bus
);

   localparam int TW = cnt_width(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   if (NUM_BTN < 1 || TICK_DIV < 2 || STABLE_SAMPLES < 1 || LONG_SAMPLES < 1) begin : g_bad_param
      $error("btn_debounce_multi: parameter out of range");
   end

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          sample_tick;

   assign sample_tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      tick_cnt_d = sample_tick ? '0 : tick_cnt_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) tick_cnt_q <= '0;
      else     tick_cnt_q <= tick_cnt_d;
   end

   logic [NUM_BTN-1:0] level_w, press_w, release_w, long_w, held_w;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .LONG_SAMPLES   (LONG_SAMPLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .sample_tick (sample_tick),
         .pin         (bus.btn_in[i]),
         .level_o     (level_w[i]),
         .press_o     (press_w[i]),
         .release_o   (release_w[i]),
         .long_o      (long_w[i]),
         .held_o      (held_w[i])
      );
   end

   assign bus.btn_level   = level_w;
   assign bus.btn_press   = press_w;
   assign bus.btn_release = release_w;
   assign bus.btn_long    = long_w;
   assign bus.btn_held    = held_w;

endmodule
